// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
// Imported by the bus interface, the pick logic and the arbiter top.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GNT_I = ST_GNT_I,
    GNT_D = ST_GNT_D
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Block-transfer bus between a cache and memory.
// The master issues read/write requests; the slave returns data and ready.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output read, write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way requester pick: round-robin on ties,
// or strict D-cache priority when FIXED_PRIO is set.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] pend,
  input  logic       last,
  output logic       vld,
  output logic       pick
);

  always_comb begin
    vld  = |pend;
    pick = REQ_I;
    unique case (pend)
      // on a tie the side not served last wins
      2'b11:   pick = FIXED_PRIO ? REQ_D : ~last;
      2'b10:   pick = REQ_D;
      default: pick = REQ_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 128-bit memory port between the I-cache and D-cache,
// serialising block transfers with a three-state grant FSM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.slave  i_mem,
  mem_arbiter_if.slave  d_mem,
  mem_arbiter_if.master mem,
  output logic [1:0]    grant
);

  state_t state_q, state_d;
  logic   last_q, last_d;

  logic              pick_vld;
  logic              pick;
  logic [1:0]        pend;

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              i_rdy;
  logic              d_rdy;
  logic [1:0]        gnt;

  assign pend = {d_mem.read | d_mem.write,
                 i_mem.read | i_mem.write};

  rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .pend(pend),
    .last(last_q),
    .vld (pick_vld),
    .pick(pick)
  );

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= IDLE;
      last_q  <= REQ_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = '0;
    i_rdy   = 1'b0;
    d_rdy   = 1'b0;
    gnt     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (pick_vld)
          state_d = (pick == REQ_D) ? GNT_D : GNT_I;
      end
      GNT_I: begin
        rd    = i_mem.read;
        wr    = i_mem.write;
        addr  = i_mem.addr;
        wdata = i_mem.wdata;
        i_rdy = mem.ready;
        gnt   = 2'b01;
        if (mem.ready) begin
          state_d = IDLE;
          last_d  = REQ_I;
        end
      end
      GNT_D: begin
        rd    = d_mem.read;
        wr    = d_mem.write;
        addr  = d_mem.addr;
        wdata = d_mem.wdata;
        d_rdy = mem.ready;
        gnt   = 2'b10;
        if (mem.ready) begin
          state_d = IDLE;
          last_d  = REQ_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.read    = rd;
  assign mem.write   = wr;
  assign mem.addr    = addr;
  assign mem.wdata   = wdata;
  assign i_mem.ready = i_rdy;
  assign d_mem.ready = d_rdy;
  // read data is broadcast; each cache latches only on its own ready
  assign i_mem.rdata = mem.rdata;
  assign d_mem.rdata = mem.rdata;
  assign grant       = gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a round-robin instance and a
// fixed-priority instance, with a queue of expected memory requests.
module tb_mem_arbiter;

  typedef struct packed {
    logic         is_d;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic proc_reset;
  logic [1:0] grant;
  logic [1:0] fgrant;
  int compared = 0;
  int mism = 0;
  int cyc = 0;
  req_t sb[$];

  mem_arbiter_if ci();
  mem_arbiter_if cd();
  mem_arbiter_if cm();
  mem_arbiter_if fi();
  mem_arbiter_if fd();
  mem_arbiter_if fm();

  mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem(ci), .d_mem(cd), .mem(cm), .grant(grant)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem(fi), .d_mem(fd), .mem(fm), .grant(fgrant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!proc_reset) begin
      assert (!(ci.read && ci.write)) else $error("I-cache read+write together");
      assert (!(cd.read && cd.write)) else $error("D-cache read+write together");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ci.read = 0; ci.write = 0; ci.addr = '0; ci.wdata = '0;
    cd.read = 0; cd.write = 0; cd.addr = '0; cd.wdata = '0;
    cm.rdata = '0; cm.ready = 0;
    fi.read = 0; fi.write = 0; fi.addr = '0; fi.wdata = '0;
    fd.read = 0; fd.write = 0; fd.addr = '0; fd.wdata = '0;
    fm.rdata = '0; fm.ready = 0;
  endtask

  task automatic do_reset();
    proc_reset = 1;
    clear_inputs();
    sb.delete();
    step();
    proc_reset = 0;
    step();
  endtask

  // memory model: wait for the forwarded request, check it, answer after lat cycles
  task automatic serve(input int lat, output int req_cyc, output int rdy_cyc);
    int n;
    req_t e;
    logic [127:0] rd;
    logic gd;
    logic [1:0] eg;
    #1;
    n = 0;
    while (!(cm.read || cm.write) && n < 50) begin
      step();
      n++;
    end
    req_cyc = cyc;
    rdy_cyc = cyc;
    compared++;
    if (n >= 50) begin
      mism++;
      $display("FAIL serve_wait: no memory request, want one within 50 cycles");
      return;
    end
    if (sb.size() == 0) begin
      mism++;
      $display("FAIL serve_order: unexpected request addr=%h, want none", cm.addr);
      return;
    end
    e = sb.pop_front();
    eg = e.is_d ? 2'b10 : 2'b01;
    if (cm.write !== e.wr || cm.read !== ~e.wr || cm.addr !== e.addr ||
        cm.wdata !== e.wdata || grant !== eg) begin
      mism++;
      $display("FAIL serve_req: got w=%b r=%b a=%h g=%b wd=%h, want w=%b a=%h g=%b wd=%h",
               cm.write, cm.read, cm.addr, grant, cm.wdata, e.wr, e.addr, eg, e.wdata);
    end
    gd = grant[1];
    repeat (lat) step();
    rd = {$urandom, $urandom, $urandom, $urandom};
    cm.rdata = rd;
    cm.ready = 1;
    #1;
    rdy_cyc = cyc;
    compared++;
    if (gd ? (cd.ready !== 1'b1 || ci.ready !== 1'b0 || cd.rdata !== rd)
           : (ci.ready !== 1'b1 || cd.ready !== 1'b0 || ci.rdata !== rd)) begin
      mism++;
      $display("FAIL serve_ready: got i_rdy=%b d_rdy=%b, want %s ready only",
               ci.ready, cd.ready, gd ? "D" : "I");
    end
    step();
    cm.ready = 0;
    if (gd) begin
      cd.read = 0; cd.write = 0;
    end else begin
      ci.read = 0; ci.write = 0;
    end
  endtask

  task automatic test_reset();
    logic [127:0] rd;
    proc_reset = 1;
    clear_inputs();
    ci.read = 1; ci.addr = 28'h1234567;
    rd = {$urandom, $urandom, $urandom, $urandom};
    cm.rdata = rd;
    #1;
    compared++;
    if (grant !== 2'b00 || fgrant !== 2'b00) begin
      mism++;
      $display("FAIL reset_grant: got %b/%b, want 00/00", grant, fgrant);
    end
    compared++;
    if (cm.read !== 0 || cm.write !== 0 || cm.addr !== '0 || cm.wdata !== '0) begin
      mism++;
      $display("FAIL reset_mem: got r=%b w=%b a=%h, want all 0", cm.read, cm.write, cm.addr);
    end
    compared++;
    if (ci.ready !== 0 || cd.ready !== 0) begin
      mism++;
      $display("FAIL reset_ready: got i=%b d=%b, want 0 0", ci.ready, cd.ready);
    end
    compared++;
    if (ci.rdata !== rd || cd.rdata !== rd) begin
      mism++;
      $display("FAIL reset_rdata: got %h, want %h", ci.rdata, rd);
    end
    step();
    ci.read = 0;
    proc_reset = 0;
    step();
  endtask

  task automatic test_lone_iread();
    req_t e;
    do_reset();
    ci.read = 1; ci.addr = 28'h0000010;
    sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 28'h0000010, wdata: '0});
    step();
    compared++;
    e = sb.pop_front();
    if (cm.read !== 1'b1 || cm.write !== 1'b0 || cm.addr !== e.addr || grant !== 2'b01) begin
      mism++;
      $display("FAIL iread_cycle1: got r=%b a=%h g=%b, want r=1 a=%h g=01",
               cm.read, cm.addr, grant, e.addr);
    end
    repeat (4) step();
    cm.ready = 1;
    #1;
    compared++;
    if (ci.ready !== 1'b1 || cd.ready !== 1'b0) begin
      mism++;
      $display("FAIL iread_ready5: got i=%b d=%b, want 1 0", ci.ready, cd.ready);
    end
    step();
    cm.ready = 0;
    ci.read = 0;
    #1;
    compared++;
    if (grant !== 2'b00 || cm.read !== 1'b0) begin
      mism++;
      $display("FAIL iread_idle6: got g=%b r=%b, want 00 0", grant, cm.read);
    end
  endtask

  task automatic test_rr_simul();
    int rq1, rd1, rq2, rd2;
    do_reset();
    cd.read = 1; cd.addr = 28'h0000200;
    ci.read = 1; ci.addr = 28'h0000100;
    sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 28'h0000200, wdata: '0});
    sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 28'h0000100, wdata: '0});
    serve(2, rq1, rd1);
    serve(1, rq2, rd2);
    compared++;
    if (rq2 !== rd1 + 2) begin
      mism++;
      $display("FAIL rr_gap: I request at cycle %0d, want %0d", rq2, rd1 + 2);
    end
  endtask

  task automatic test_dirty_miss();
    int rq, rd;
    logic [127:0] dead;
    dead = {4{32'hDEADBEEF}};
    do_reset();
    cd.write = 1; cd.addr = 28'h00000A3; cd.wdata = dead;
    ci.read = 1; ci.addr = 28'h0000040;
    sb.push_back('{is_d: 1'b1, wr: 1'b1, addr: 28'h00000A3, wdata: dead});
    sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 28'h0000040, wdata: '0});
    sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 28'h00000A3, wdata: '0});
    serve(2, rq, rd);
    cd.read = 1; cd.addr = 28'h00000A3; cd.wdata = '0;
    serve(1, rq, rd);
    serve(3, rq, rd);
    compared++;
    if (sb.size() != 0) begin
      mism++;
      $display("FAIL dirty_left: %0d requests never seen, want 0", sb.size());
    end
  endtask

  task automatic test_fixed_prio();
    int n;
    do_reset();
    fd.read = 1; fd.addr = 28'h0000020;
    fi.read = 1; fi.addr = 28'h0000030;
    #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!fm.read && n < 20) begin
        step();
        n++;
      end
      compared++;
      if (n >= 20 || fgrant !== 2'b10 || fm.addr !== 28'h0000020) begin
        mism++;
        $display("FAIL fp_d_grant: round %0d got g=%b a=%h, want 10 %h",
                 k, fgrant, fm.addr, 28'h0000020);
      end
      step();
      fm.ready = 1;
      #1;
      compared++;
      if (fd.ready !== 1'b1 || fi.ready !== 1'b0) begin
        mism++;
        $display("FAIL fp_d_ready: got i=%b d=%b, want 0 1", fi.ready, fd.ready);
      end
      step();
      fm.ready = 0;
      if (k == 2) fd.read = 0;
      #1;
    end
    step();
    compared++;
    if (fgrant !== 2'b01 || fm.read !== 1'b1 || fm.addr !== 28'h0000030) begin
      mism++;
      $display("FAIL fp_i_grant: got g=%b a=%h, want 01 %h", fgrant, fm.addr, 28'h0000030);
    end
    fd.read = 1;
    fm.ready = 1;
    #1;
    compared++;
    if (fi.ready !== 1'b1 || fd.ready !== 1'b0) begin
      mism++;
      $display("FAIL fp_i_ready: got i=%b d=%b, want 1 0", fi.ready, fd.ready);
    end
    step();
    fm.ready = 0;
    fi.read = 0;
    fd.read = 0;
  endtask

  task automatic test_async_reset();
    int rq, rd;
    do_reset();
    cd.read = 1; cd.addr = 28'h0000055;
    step();
    compared++;
    if (grant !== 2'b10 || cm.read !== 1'b1) begin
      mism++;
      $display("FAIL ar_pre: got g=%b r=%b, want 10 1", grant, cm.read);
    end
    #1;
    proc_reset = 1;
    #1;
    compared++;
    if (cm.read !== 1'b0 || cm.write !== 1'b0 || grant !== 2'b00) begin
      mism++;
      $display("FAIL ar_abort: got r=%b w=%b g=%b, want 0 0 00", cm.read, cm.write, grant);
    end
    step();
    proc_reset = 0;
    step();
    compared++;
    if (grant !== 2'b10 || cm.read !== 1'b1) begin
      mism++;
      $display("FAIL ar_regrant: got g=%b r=%b, want 10 1", grant, cm.read);
    end
    sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 28'h0000055, wdata: '0});
    serve(1, rq, rd);
  endtask

  task automatic test_stray_ready();
    do_reset();
    cm.ready = 1;
    #1;
    compared++;
    if (ci.ready !== 1'b0 || cd.ready !== 1'b0 || grant !== 2'b00) begin
      mism++;
      $display("FAIL stray_ready: got i=%b d=%b g=%b, want 0 0 00", ci.ready, cd.ready, grant);
    end
    step();
    cm.ready = 0;
    #1;
    compared++;
    if (grant !== 2'b00 || cm.read !== 1'b0) begin
      mism++;
      $display("FAIL stray_state: got g=%b r=%b, want 00 0", grant, cm.read);
    end
  endtask

  task automatic test_drop_request();
    do_reset();
    ci.read = 1; ci.addr = 28'h0000077;
    step();
    ci.read = 0;
    #1;
    compared++;
    if (grant !== 2'b01 || cm.read !== 1'b0 || cm.addr !== 28'h0000077) begin
      mism++;
      $display("FAIL drop_hold: got g=%b r=%b a=%h, want 01 0 %h",
               grant, cm.read, cm.addr, 28'h0000077);
    end
    step();
    compared++;
    if (grant !== 2'b01) begin
      mism++;
      $display("FAIL drop_keep: got g=%b, want 01", grant);
    end
    cm.ready = 1;
    #1;
    compared++;
    if (ci.ready !== 1'b1 || cd.ready !== 1'b0) begin
      mism++;
      $display("FAIL drop_ready: got i=%b d=%b, want 1 0", ci.ready, cd.ready);
    end
    step();
    cm.ready = 0;
    #1;
    compared++;
    if (grant !== 2'b00) begin
      mism++;
      $display("FAIL drop_idle: got g=%b, want 00", grant);
    end
  endtask

  initial begin
    proc_reset = 1;
    clear_inputs();
    test_reset();
    test_lone_iread();
    test_rr_simul();
    test_dirty_miss();
    test_fixed_prio();
    test_async_reset();
    test_stray_ready();
    test_drop_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
